// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types, constants and counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   localparam int c_DEFAULT_CLKS_PER_BAUD = 868;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   // Never returns zero so a counter for a range of 1 still has one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Brief    : Bit-period down-counter; ticks when the count reaches zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BAUD = c_DEFAULT_CLKS_PER_BAUD
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_restart,
   output logic o_tick
);

   localparam int CNT_W = cnt_width(CLKS_PER_BAUD);
   localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(CLKS_PER_BAUD - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign o_tick = (count_q == '0);

   // Reload on every tick too, so consecutive bits in one state stay aligned.
   always_comb begin
      count_d = count_q - CNT_W'(1);
      if (i_restart || o_tick) begin
         count_d = c_RELOAD;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : FIFO-draining UART transmitter, 8N1 or 8E1 when
//            UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BAUD = c_DEFAULT_CLKS_PER_BAUD,
   parameter int DATA_BITS     = 8
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n_w,
   input  logic [DATA_BITS-1:0] i_data_w,
   input  logic                 i_empty_w,
   output logic                 o_read_w,
   output logic                 o_tx_w,
   output logic                 o_busy_w
);

   localparam int IDX_W = cnt_width(DATA_BITS);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(DATA_BITS - 1);

   tx_state_e            state_q;
   tx_state_e            state_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [IDX_W-1:0]     idx_q;
   logic [IDX_W-1:0]     idx_d;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q;
   logic                 parity_d;
`endif

   logic w_tick;
   logic w_restart;
   logic w_pop;

   assign w_restart = (state_d != state_q);

   uart_baud_gen #(
      .CLKS_PER_BAUD (CLKS_PER_BAUD)
   ) u_baud_gen (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n_w),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      w_pop   = 1'b0;
      o_tx_w  = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         TX_IDLE: begin
            // Reset gating keeps the pop strobe low while the block is held.
            if (!i_empty_w && i_reset_n_w) begin
               w_pop   = 1'b1;
               state_d = TX_START;
            end
         end
         TX_START: begin
            o_tx_w = 1'b0;
            if (w_tick) begin
               state_d = TX_DATA;
               idx_d   = '0;
            end
         end
         TX_DATA: begin
            o_tx_w = shift_q[0];
            if (w_tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == c_LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            o_tx_w = parity_q;
            if (w_tick) begin
               state_d = TX_STOP;
            end
         end
`endif
         TX_STOP: begin
            if (w_tick) begin
               if (!i_empty_w) begin
                  w_pop   = 1'b1;
                  state_d = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: begin
            state_d = TX_IDLE;
         end
      endcase

      if (w_pop) begin
         shift_d = i_data_w;
`ifdef UART_TX_PARITY_EN
         parity_d = ^i_data_w;
`endif
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n_w) begin
      if (!i_reset_n_w) begin
         state_q  <= TX_IDLE;
         shift_q  <= '0;
         idx_q    <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         idx_q    <= idx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign o_read_w = w_pop;
   assign o_busy_w = (state_q != TX_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that drains the transmit FIFO and drives the UART TX line. It sits directly downstream of the TX FIFO. It reads the FIFO's show-ahead data output and empty flag, pops one word per frame via the FIFO read strobe, and shifts it out as 8N1 (or 8E1) with configurable baud divisor. It is a pure consumer: it never stalls the FIFO and never writes to it.

## Interface
- CLKS_PER_BAUD, 868, system clocks per bit period (100 MHz / 115200); legal range ≥ 2
- DATA_BITS, 8, data bits per frame, LSB first; must equal the FIFO width
- i_clk  input  1  system clock, all state on rising edge
- i_reset_n_w  input  1  asynchronous, active-low reset
- i_data_w  input  DATA_BITS  FIFO output word, valid whenever i_empty_w is low
- i_empty_w  input  1  FIFO empty flag
- o_read_w  output  1  FIFO pop strobe, one cycle per frame
- o_tx_w  output  1  serial line, idle high
- o_busy_w  output  1  high while a frame is in flight (state ≠ IDLE)

## Operation
- States: IDLE, START, DATA, PARITY (only with macro), STOP.
- Baud counter: width $clog2(CLKS_PER_BAUD). Loads CLKS_PER_BAUD-1 on every state entry and decrements. baud_tick = (counter == 0).
- IDLE: o_tx_w=1. If !i_empty_w, then o_read_w=1 this cycle, i_data_w is latched into the shift register on the same edge, and the state goes to START.
- START: o_tx_w=0 for CLKS_PER_BAUD cycles. On baud_tick go to DATA with bit index 0.
- DATA: o_tx_w = shift[0]. On baud_tick, shift right. The bit index increments (width $clog2(DATA_BITS)). After DATA_BITS bits go to PARITY, or to STOP if parity is compiled out.
- PARITY: o_tx_w = XOR of the latched word (even parity) for one bit period, then STOP.
- STOP: o_tx_w=1 for one bit period. On baud_tick:
  - if !i_empty_w, pop (o_read_w=1), latch, and go directly to START, giving zero idle gap;
  - else go to IDLE.
- o_read_w is a combinational decode of registered state, baud_tick and i_empty_w: (IDLE | (STOP & baud_tick)) & !i_empty_w. It is never asserted while i_empty_w=1, so the FIFO is never underflowed.
- i_data_w is sampled only on pop edges. Changes at other times have no effect on the frame in flight.

## Timing
- Reset values, asserted asynchronously: state IDLE, o_tx_w=1, o_read_w=0, o_busy_w=0, counters 0, shift register 0.
- Latency: the first cycle with i_empty_w=0 in IDLE raises o_read_w combinationally. o_tx_w falls on the following edge.
- Frame length: exactly (2 + DATA_BITS [+1 with parity]) × CLKS_PER_BAUD cycles, measured from the start-bit falling edge to the end of the stop bit.
- Back-to-back frames have no gap: the next start bit begins on the edge after the last stop-bit cycle.
- Reset mid-frame: o_tx_w returns high immediately and the frame is truncated. The popped word is lost and no further pop occurs until reset is released.
- i_empty_w rising mid-frame has no effect. The frame completes and the block then idles.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state is present, giving an even parity bit and an 11-bit frame for DATA_BITS=8.
- UART_TX_PARITY_EN undefined: PARITY state and parity logic are absent, giving a 10-bit frame (8N1).

## Structure
- Package uart_pkg holds:
  - the tx state encoding constants (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit);
  - the default CLKS_PER_BAUD;
  - a shared clog2-based counter-width constant function, reused by the future uart_rx.
- Sub-module uart_baud_gen: down-counter with i_restart and o_tick, parameterised by CLKS_PER_BAUD. It is shared with the receiver.

## Test plan
- Single byte, no parity, CLKS_PER_BAUD=4: FIFO holds 0x55.
  - One o_read_w pulse.
  - o_tx_w shows 0, then 1,0,1,0,1,0,1,0, then 1, each level held 4 cycles (40 cycles total).
  - o_busy_w is then low.
- Back-to-back: FIFO holds 0xA3, 0x0F.
  - Two o_read_w pulses exactly 40 cycles apart.
  - No idle cycle between the stop bit and the second start bit.
  - Decoded bytes are 0xA3, then 0x0F.
- Empty FIFO: i_empty_w=1 for 100 cycles.
  - o_read_w=0, o_tx_w=1 and o_busy_w=0 throughout.
- Reset mid-frame: assert i_reset_n_w=0 during the DATA state of 0xFF.
  - o_tx_w=1 asynchronously and the state is IDLE.
  - After release with the FIFO still non-empty, a fresh frame starts with a new pop.
- Parity, with UART_TX_PARITY_EN and CLKS_PER_BAUD=4: byte 0x07 gives parity bit 1; byte 0x03 gives parity bit 0. Frame length is 44 cycles.
- Data stability: toggle i_data_w randomly during a frame. The transmitted bits match the word present on the pop edge.
